// File: rtl/instruction_loader_if.sv
// Loader-side handshake and memory write bundle for instruction_loader_mod.
// Host drives the load controls and word stream; the loader drives the byte port.
interface instruction_loader_if #(
    parameter int N = 10
);
    logic         start_i;
    logic [N-1:0] base_addr_i;
    logic [N-2:0] num_words_i;
    logic         word_valid_i;
    logic [31:0]  word_i;
    logic         word_ready_o;
    logic         mem_we_o;
    logic [N-1:0] mem_addr_o;
    logic [7:0]   mem_wdata_o;
    logic         busy_o;
    logic         done_o;
    logic         overflow_o;

    modport master (
        output start_i, base_addr_i, num_words_i,
        output word_valid_i, word_i,
        input  word_ready_o, mem_we_o, mem_addr_o,
        input  mem_wdata_o, busy_o, done_o, overflow_o
    );

    modport slave (
        input  start_i, base_addr_i, num_words_i,
        input  word_valid_i, word_i,
        output word_ready_o, mem_we_o, mem_addr_o,
        output mem_wdata_o, busy_o, done_o, overflow_o
    );
endinterface

// File: rtl/instruction_loader_mod.sv
// Streams 32-bit words into byte-wide instruction memory, MSB at lowest address.
// Holds the core off with busy_o while a load session runs.
module instruction_loader_mod #(
    parameter int N = 10,
    parameter int M = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    instruction_loader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        WRITE,
        DONE
    } state_t;

    localparam logic [N-2:0] REM_ONE   = (N-1)'(1);
    localparam logic [N-1:0] LAST_WORD = N'(M - 4);
    localparam logic [N-1:0] ALIGN     = ~N'(3);

    state_t       state;
    logic [N-1:0] addr;
    logic [N-2:0] remaining;
    logic [31:0]  word_q;
    logic [1:0]   k;
    logic [1:0]   k_nx;
    logic [7:0]   next_byte;

    assign k_nx = k + 2'd1;

    always_comb begin
        next_byte = word_q[31:24];
        unique case (k_nx)
            2'd0: next_byte = word_q[31:24];
            2'd1: next_byte = word_q[23:16];
            2'd2: next_byte = word_q[15:8];
            2'd3: next_byte = word_q[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            addr             <= '0;
            remaining        <= '0;
            word_q           <= '0;
            k                <= '0;
            bus.word_ready_o <= 1'b0;
            bus.mem_we_o     <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_wdata_o  <= '0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.overflow_o   <= 1'b0;
        end else begin
            // Byte port idles at zero unless a write is being presented.
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.done_o      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        addr           <= bus.base_addr_i & ALIGN;
                        remaining      <= bus.num_words_i;
                        bus.overflow_o <= 1'b0;
                        if (bus.num_words_i == '0) begin
                            state      <= DONE;
                            bus.done_o <= 1'b1;
                        end else begin
                            state            <= WAIT_WORD;
                            bus.word_ready_o <= 1'b1;
                            bus.busy_o       <= 1'b1;
                        end
                    end
                end
                WAIT_WORD: begin
                    if (bus.word_valid_i) begin
                        word_q           <= bus.word_i;
                        k                <= 2'd0;
                        state            <= WRITE;
                        bus.word_ready_o <= 1'b0;
                        bus.mem_we_o     <= 1'b1;
                        bus.mem_addr_o   <= addr;
                        bus.mem_wdata_o  <= bus.word_i[31:24];
                    end
                end
                WRITE: begin
                    if (k != 2'd3) begin
                        k               <= k_nx;
                        bus.mem_we_o    <= 1'b1;
                        bus.mem_addr_o  <= addr + {{(N-2){1'b0}}, k_nx};
                        bus.mem_wdata_o <= next_byte;
                    end else begin
                        remaining <= remaining - REM_ONE;
                        addr      <= addr + N'(4);
                        if (remaining == REM_ONE) begin
                            state      <= DONE;
                            bus.done_o <= 1'b1;
                            bus.busy_o <= 1'b0;
                        end else if (addr == LAST_WORD) begin
                            // Words remain but the next one would wrap to 0.
                            state          <= DONE;
                            bus.done_o     <= 1'b1;
                            bus.busy_o     <= 1'b0;
                            bus.overflow_o <= 1'b1;
                        end else begin
                            state            <= WAIT_WORD;
                            bus.word_ready_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_loader_mod.sv
// Table-driven and randomized bench for instruction_loader_mod.
// Expected byte writes come from a word-level address model.
module tb_instruction_loader_mod;
    localparam int N = 10;
    localparam int M = 1024;

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        string      tag;
        logic [9:0] base;
        int         num;
        int         gap;
        logic [31:0] w0;
        int         exp_w;
        int         exp_o;
        int         exp_lat;
        int         exp_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   rdy_cnt = 0;
    bit   busy_seen = 0;
    wr_t  wq[$];
    logic [7:0] mem_model [M];

    instruction_loader_if #(.N(N)) bus ();

    instruction_loader_mod #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.mem_we_o) begin
            wq.push_back('{bus.mem_addr_o, bus.mem_wdata_o});
            mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
        end
        if (bus.done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.word_ready_o) rdy_cnt++;
        if (bus.busy_o) busy_seen = 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.word_ready_o), 0);
        chk({tag, "_we"}, 32'(bus.mem_we_o), 0);
        chk({tag, "_addr"}, 32'(bus.mem_addr_o), 0);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata_o), 0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 0);
        chk({tag, "_done"}, 32'(bus.done_o), 0);
        chk({tag, "_ovf"}, 32'(bus.overflow_o), 0);
    endtask

    task automatic run(input string tag, input logic [9:0] base,
                       input int num, input int gap,
                       input logic [31:0] w0, input int exp_w,
                       input int exp_o, input int exp_lat,
                       input int exp_rdy);
        logic [31:0] ws[$];
        wr_t         eq[$];
        logic [9:0]  a;
        int          m_o;
        int          e_cyc;
        int          nm;
        bit          stop;
        bit          got;
        for (int i = 0; i < num; i++)
            ws.push_back(i == 0 ? w0 : $urandom);
        // Reference: word-aligned base, MSB first, stop early on wrap.
        a   = base & 10'h3FC;
        m_o = 0;
        for (int i = 0; i < num; i++) begin
            for (int b = 0; b < 4; b++)
                eq.push_back('{a + 10'(b), 8'(ws[i] >> (24 - 8 * b))});
            a = a + 10'd4;
            if (i < num - 1 && a == 10'd0) begin
                m_o = 1;
                break;
            end
        end
        if (exp_w < 0) exp_w = eq.size();
        if (exp_o < 0) exp_o = m_o;
        if (exp_lat == -2) exp_lat = (gap == 0) ? 2 + 5 * (eq.size() / 4) : -1;

        wq.delete();
        done_cnt  = 0;
        rdy_cnt   = 0;
        busy_seen = 0;
        stop      = 0;
        @(posedge clk); #1;
        bus.start_i     = 1'b1;
        bus.base_addr_i = base;
        bus.num_words_i = 9'(num);
        @(posedge clk); #1;
        e_cyc = cyc;
        bus.start_i = 1'b0;
        chk({tag, "_ovfclr"}, 32'(bus.overflow_o), 0);
        chk({tag, "_busy_start"}, 32'(bus.busy_o), 32'(num != 0));

        for (int i = 0; i < num && !stop; i++) begin
            if (i > 0 && gap > 0) begin
                bus.word_valid_i = 1'b0;
                got = 0;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (bus.done_o) begin stop = 1; break; end
                    if (bus.word_ready_o) begin got = 1; break; end
                end
                if (stop) break;
                if (!got) begin
                    chk({tag, "_ready_timeout"}, 0, 1);
                    stop = 1;
                    break;
                end
                repeat (gap) @(posedge clk);
                #1;
                chk({tag, "_gap_nowrite"}, wq.size(), 4 * i);
            end
            bus.word_valid_i = 1'b1;
            bus.word_i       = ws[i];
            got = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (bus.done_o) begin stop = 1; break; end
                if (bus.word_ready_o) begin
                    got = 1;
                    @(posedge clk); #1;
                    break;
                end
            end
            if (!stop && !got) begin
                chk({tag, "_hs_timeout"}, 0, 1);
                stop = 1;
            end
        end
        bus.word_valid_i = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (done_cnt > 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;

        nm = 0;
        for (int i = 0; i < eq.size(); i++)
            if (i < wq.size() && wq[i].a == eq[i].a && wq[i].d == eq[i].d) nm++;
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_nwrites"}, wq.size(), exp_w);
        chk({tag, "_bytes"}, nm, eq.size());
        chk({tag, "_ovf"}, 32'(bus.overflow_o), 32'(exp_o));
        chk({tag, "_busy_after"}, 32'(bus.busy_o), 0);
        chk({tag, "_busy_seen"}, 32'(busy_seen), 32'(num != 0));
        if (exp_lat >= 0) chk({tag, "_latency"}, done_cyc - e_cyc + 2, exp_lat);
        if (exp_rdy >= 0) chk({tag, "_ready_cycles"}, rdy_cnt, exp_rdy);
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{"single",   10'h010, 1, 0, 32'hDEADBEEF, 4, 0, 7, 1};
        tbl[1] = '{"stream",   10'h000, 3, 0, 32'h01234567, 12, 0, 17, 3};
        tbl[2] = '{"stall",    10'h020, 2, 7, 32'hCAFEF00D, 8, 0, -1, 9};
        tbl[3] = '{"misalign", 10'h103, 1, 0, 32'hA5C3E1F0, 4, 0, 7, 1};
        tbl[4] = '{"zero",     10'h155, 0, 0, 32'h0, 0, 0, 2, 0};
        tbl[5] = '{"ovf",      10'h3FC, 2, 0, 32'h89ABCDEF, 4, 1, 7, 1};
        tbl[6] = '{"top_fit",  10'h3F8, 2, 0, 32'h13579BDF, 8, 0, 12, 2};

        for (int i = 0; i < M; i++) mem_model[i] = 8'h00;
        bus.start_i      = 1'b0;
        bus.base_addr_i  = '0;
        bus.num_words_i  = '0;
        bus.word_valid_i = 1'b0;
        bus.word_i       = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run(tbl[i].tag, tbl[i].base, tbl[i].num, tbl[i].gap, tbl[i].w0,
                tbl[i].exp_w, tbl[i].exp_o, tbl[i].exp_lat, tbl[i].exp_rdy);
            if (i == 0)
                chk("fetch_010", {mem_model[16], mem_model[17],
                                  mem_model[18], mem_model[19]}, 32'hDEADBEEF);
            if (i == 3)
                chk("misalign_first", 32'(wq.size() > 0 ? wq[0].a : 10'h3FF), 32'h100);
            if (i == 5) begin
                repeat (5) @(posedge clk);
                #1;
                chk("ovf_sticky", 32'(bus.overflow_o), 1);
            end
        end

        // Abort a session right after byte 1 of its first word is committed.
        wq.delete();
        @(posedge clk); #1;
        bus.start_i     = 1'b1;
        bus.base_addr_i = 10'h040;
        bus.num_words_i = 9'd2;
        @(posedge clk); #1;
        bus.start_i      = 1'b0;
        bus.word_valid_i = 1'b1;
        bus.word_i       = 32'h11223344;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            if (wq.size() >= 2) break;
        end
        #1;
        rst_n = 1'b0;
        bus.word_valid_i = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_nwrites", wq.size(), 2);
        rst_n = 1'b1;
        run("post_rst", 10'h040, 2, 0, 32'h55667788, 8, 0, 12, 2);

        for (int r = 0; r < 12; r++) begin
            logic [9:0] b;
            if ($urandom_range(0, 2) == 0)
                b = 10'(M - 4 * $urandom_range(1, 4) + $urandom_range(0, 3));
            else
                b = 10'($urandom_range(0, M - 1));
            run($sformatf("rnd%0d", r), b, $urandom_range(0, 6),
                $urandom_range(0, 4), $urandom, -1, -1, -2, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/instruction_loader_mod.md
# instruction_loader_mod

Program loader that fills the byte-addressed instruction memory from a 32-bit word stream before or between executions of the one-cycle RISC. It accepts words over a valid/ready handshake and splits each word into four byte writes, most significant byte at the lowest address. This is the same byte order in which the instruction fetch path reassembles words. It sits between a host/boot source and the byte write port of the instruction memory, and holds the core off via `busy_o` while loading.

## Interface
- `N`, 10, byte address width.
- `M`, 1024, memory depth in bytes; must equal 2^N.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  begin a load session; sampled only in IDLE.
- `base_addr_i`  in  N  first byte address; bits [1:0] ignored (forced to 0, word aligned).
- `num_words_i`  in  N-1  words to load; 0 is legal.
- `word_valid_i`  in  1  `word_i` is valid.
- `word_i`  in  32  instruction word.
- `word_ready_o`  out  1  loader can accept a word this cycle.
- `mem_we_o`  out  1  byte write enable to instruction memory.
- `mem_addr_o`  out  N  byte write address.
- `mem_wdata_o`  out  8  byte write data.
- `busy_o`  out  1  load session in progress; the core must stall.
- `done_o`  out  1  one-cycle pulse at session end.
- `overflow_o`  out  1  sticky: session ended early on address wrap; cleared by the next accepted `start_i`.

## Operation
- States: IDLE, WAIT_WORD, WRITE, DONE.
- IDLE, `start_i`=1:
  - Latch `{base_addr_i[N-1:2],2'b00}` into the address counter.
  - Latch `num_words_i` into the remaining-words counter.
  - Clear `overflow_o`.
  - Go to DONE if `num_words_i`=0, else go to WAIT_WORD.
- WAIT_WORD: `word_ready_o`=1. When `word_valid_i`=1, capture `word_i` and go to WRITE.
- WRITE: four byte cycles, k=0..3.
  - `mem_we_o`=1, `mem_addr_o`=addr+k, `mem_wdata_o`=`word[31-8k:24-8k]`.
  - After k=3: decrement remaining and advance addr by 4, modulo M.
  - Remaining=0 → go to DONE.
  - Remaining>0 and the just-written byte was at M-1 → set `overflow_o`, go to DONE.
  - Otherwise → go to WAIT_WORD.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- `busy_o`=1 in WAIT_WORD and WRITE; 0 in IDLE and DONE.
- `start_i` outside IDLE is ignored. `word_valid_i` while `word_ready_o`=0 is ignored; the source must hold the word until the handshake.
- All outputs are registered. `mem_addr_o` and `mem_wdata_o` are don't-care when `mem_we_o`=0 but drive 0 in IDLE.

## Timing
- Reset (async assert): state IDLE, all counters 0. `word_ready_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `busy_o`, `done_o`, `overflow_o` all 0.
- Reset mid-session aborts immediately. Bytes already written stay in memory; no rollback.
- Start sampled at edge E: `busy_o` and `word_ready_o` are high in the cycle after E (or `done_o` high, if `num_words_i`=0).
- Handshake sampled at edge H:
  - Bytes 0..3 are presented in the four cycles after H and committed at edges H+1..H+4.
  - `word_ready_o` drops in the cycle after H.
- After H+4, either `word_ready_o`=1 (more words) or `done_o`=1 (last word or overflow).
- Throughput is 5 cycles per word when `word_valid_i` is held high.
- Session latency for W words with continuous valid: 1 + 5W + 1 cycles from start edge to `done_o`, with `done_o` in the last cycle.
- Address arithmetic is N-bit, wrapping modulo M. Overflow is detected only at a word boundary with words still remaining.

## Test plan
- Single word: base 0x010, num 1, word 0xDEADBEEF.
  - Writes DE@0x010, AD@0x011, BE@0x012, EF@0x013 on consecutive cycles.
  - `done_o` pulses once; `busy_o` is 0 after.
  - Fetch read at 0x010 returns 0xDEADBEEF.
- Back-to-back stream: base 0x000, num 3, `word_valid_i` held high.
  - Exactly 12 writes at 0x000..0x00B.
  - `word_ready_o` is high for one cycle per word, 5 cycles apart.
  - `done_o` is 17 cycles after the start edge.
- Stalled source: valid deasserted for 7 cycles between words.
  - `word_ready_o` stays high throughout; no `mem_we_o` during the gap.
  - Data is correct afterwards.
- Misaligned base and zero length:
  - Base 0x103 loads from 0x100.
  - `num_words_i`=0 gives `done_o` in the cycle after start, zero writes, `busy_o` never 1.
- Overflow: base 0x3FC, num 2.
  - Writes 0x3FC..0x3FF only.
  - `done_o` and `overflow_o`=1; `overflow_o` stays set until the next start, then clears.
- Reset mid-WRITE: assert `rst_n`=0 after byte 1 of a word.
  - All outputs are 0 immediately and no further writes occur.
  - A new session after reset works normally.
